// File: rtl/scan_code_gen_pkg.sv
// scan_code_gen_pkg: shared code width, mode encodings and direction constants
package scan_pkg;
  localparam int CODE_W = 3;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_AUTO = 2'b01,
    MODE_STEP = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/scan_code_gen_if.sv
// scan_code_gen_if: control inputs and decoder-select outputs of the scan code generator
interface scan_code_gen_if;
  import scan_pkg::*;
  mode_e             mode;
  logic              dir;
  logic              step;
  logic [CODE_W-1:0] load_val;
  logic              a;
  logic              b;
  logic              c;
  logic              adv;
  logic              wrap;
  modport master (output mode, dir, step, load_val, input a, b, c, adv, wrap);
  modport slave  (input mode, dir, step, load_val, output a, b, c, adv, wrap);
endinterface

// File: rtl/scan_code_gen_step_sync.sv
// step_sync_edge: two-flop synchronizer plus edge flop, emits a one-cycle rise pulse
module step_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic s1_q, s2_q, s3_q;
  // shift the asynchronous strobe through the synchronizer and edge-detect stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end
  assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/scan_code_gen.sv
// scan_code_gen: registered 3-bit decoder select code with auto-scan, single-step, hold and load
module scan_code_gen
  import scan_pkg::*;
#(
  parameter int CNT_MAX  = 49999,
  parameter int LAST_IDX = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  scan_code_gen_if.slave        bus
);
  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0]     CNT_TOP = CW'(CNT_MAX);
  localparam logic [CODE_W-1:0] LAST    = CODE_W'(LAST_IDX);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d, nxt, ld;
  logic              adv_q, adv_d, wrap_q, wrap_d;
  logic              rise, at_end, fire;
  step_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.step),
    .rise_o (rise)
  );
  // next code, prescaler and pulse flags; only the active mode's source may advance
  always_comb begin
    at_end = (bus.dir == DIR_DN) ? (code_q == '0) : (code_q == LAST);
    nxt    = at_end ? ((bus.dir == DIR_DN) ? LAST : '0)
                    : ((bus.dir == DIR_DN) ? code_q - 1'b1 : code_q + 1'b1);
    fire   = (bus.mode == MODE_AUTO && cnt_q == CNT_TOP) || (bus.mode == MODE_STEP && rise);
    ld     = (bus.load_val > LAST) ? LAST : bus.load_val;
    cnt_d  = (bus.mode == MODE_AUTO && cnt_q != CNT_TOP) ? cnt_q + 1'b1 : '0;
    code_d = (bus.mode == MODE_LOAD) ? ld : fire ? nxt : code_q;
    adv_d  = (bus.mode == MODE_LOAD) ? (ld != code_q) : fire;
    wrap_d = fire && at_end;
  end
  // code, pulses and prescaler all update on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      code_q <= '0;
      adv_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      code_q <= code_d;
      adv_q  <= adv_d;
      wrap_q <= wrap_d;
    end
  end
  assign bus.a    = code_q[2];
  assign bus.b    = code_q[1];
  assign bus.c    = code_q[0];
  assign bus.adv  = adv_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scan_code_gen.sv
// tb_scan_code_gen: directed vectors and corner sequences for scan_code_gen
module tb_scan_code_gen;
  import scan_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  scan_code_gen_if b7 ();
  scan_code_gen_if b5 ();
  scan_code_gen #(.CNT_MAX(3), .LAST_IDX(7)) dut7 (.clk(clk), .rst(rst), .bus(b7));
  scan_code_gen #(.CNT_MAX(3), .LAST_IDX(5)) dut5 (.clk(clk), .rst(rst), .bus(b5));
  always #5 clk = ~clk;
  typedef struct {
    mode_e      mode;
    logic [2:0] load_val;
    logic [2:0] code;
    logic       adv;
    logic       wrap;
  } vec_t;
  vec_t vt[9];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk7(string nm, logic [2:0] ec, logic ea, logic ew);
    chk({nm, "_code"}, {5'd0, b7.a, b7.b, b7.c}, {5'd0, ec});
    chk({nm, "_adv"},  {7'd0, b7.adv},  {7'd0, ea});
    chk({nm, "_wrap"}, {7'd0, b7.wrap}, {7'd0, ew});
  endtask
  task automatic chk5(string nm, logic [2:0] ec, logic ea, logic ew);
    chk({nm, "_code"}, {5'd0, b5.a, b5.b, b5.c}, {5'd0, ec});
    chk({nm, "_adv"},  {7'd0, b5.adv},  {7'd0, ea});
    chk({nm, "_wrap"}, {7'd0, b5.wrap}, {7'd0, ew});
  endtask
  initial begin
    logic [2:0] s5[7];
    logic [2:0] c7;
    s5 = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
    vt[0] = '{MODE_LOAD, 3'd6, 3'd6, 1'b1, 1'b0};
    vt[1] = '{MODE_LOAD, 3'd6, 3'd6, 1'b0, 1'b0};
    vt[2] = '{MODE_LOAD, 3'd6, 3'd6, 1'b0, 1'b0};
    vt[3] = '{MODE_LOAD, 3'd7, 3'd7, 1'b1, 1'b0};
    vt[4] = '{MODE_HOLD, 3'd1, 3'd7, 1'b0, 1'b0};
    vt[5] = '{MODE_STEP, 3'd1, 3'd7, 1'b0, 1'b0};
    vt[6] = '{MODE_LOAD, 3'd0, 3'd0, 1'b1, 1'b0};
    vt[7] = '{MODE_LOAD, 3'd2, 3'd2, 1'b1, 1'b0};
    vt[8] = '{MODE_HOLD, 3'd5, 3'd2, 1'b0, 1'b0};
    b7.mode = MODE_HOLD; b7.dir = DIR_UP; b7.step = 1'b0; b7.load_val = 3'd0;
    b5.mode = MODE_HOLD; b5.dir = DIR_UP; b5.step = 1'b0; b5.load_val = 3'd0;
    #12;
    chk7("reset7", 3'd0, 1'b0, 1'b0);
    chk5("reset5", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    // AUTO up over the full 0..7 range
    b7.mode = MODE_AUTO;
    for (int t = 1; t <= 32; t++) begin
      tick();
      chk7("auto_up", 3'((t / 4) % 8), (t % 4) == 0, t == 32);
    end
    b7.mode = MODE_HOLD;
    // AUTO down with LAST_IDX=5
    b5.mode = MODE_AUTO; b5.dir = DIR_DN;
    for (int t = 1; t <= 28; t++) begin
      tick();
      chk5("auto_dn", (t < 4) ? 3'd0 : s5[t / 4 - 1], (t % 4) == 0, t == 4 || t == 28);
    end
    b5.mode = MODE_HOLD;
    tick();
    chk7("hold_after_auto", 3'd0, 1'b0, 1'b0);
    // three step pulses, each held 6 clocks
    b7.mode = MODE_STEP; b7.dir = DIR_UP;
    tick();
    for (int p = 0; p < 3; p++) begin
      b7.step = 1'b1;
      tick(); chk7("step_n0", 3'(p), 1'b0, 1'b0);
      tick(); chk7("step_n1", 3'(p), 1'b0, 1'b0);
      tick(); chk7("step_n2", 3'(p + 1), 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        tick(); chk7("step_held", 3'(p + 1), 1'b0, 1'b0);
      end
      b7.step = 1'b0;
      for (int k = 0; k < 4; k++) begin
        tick(); chk7("step_low", 3'(p + 1), 1'b0, 1'b0);
      end
    end
    // step pulses while in HOLD are discarded
    b7.mode = MODE_HOLD; b7.step = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(); chk7("step_in_hold", 3'd3, 1'b0, 1'b0);
    end
    b7.step = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    // entering STEP with step already high must not advance
    b7.step = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    b7.mode = MODE_STEP;
    for (int k = 0; k < 4; k++) begin
      tick(); chk7("step_preheld", 3'd3, 1'b0, 1'b0);
    end
    b7.step = 1'b0;
    b7.mode = MODE_HOLD;
    for (int k = 0; k < 3; k++) tick();
    // table-driven LOAD/HOLD/STEP vectors
    for (int i = 0; i < 9; i++) begin
      b7.mode = vt[i].mode;
      b7.load_val = vt[i].load_val;
      tick();
      chk7($sformatf("vec%0d", i), vt[i].code, vt[i].adv, vt[i].wrap);
    end
    // LOAD clamps to LAST_IDX=5
    b5.mode = MODE_LOAD; b5.load_val = 3'd2;
    tick(); chk5("load5_2", 3'd2, 1'b1, 1'b0);
    b5.load_val = 3'd7;
    tick(); chk5("load5_clamp", 3'd5, 1'b1, 1'b0);
    tick(); chk5("load5_same", 3'd5, 1'b0, 1'b0);
    b5.mode = MODE_HOLD;
    // AUTO -> HOLD at prescaler=2, then re-entry restarts a full period
    b7.mode = MODE_AUTO;
    tick(); tick();
    chk7("pre_hold", 3'd2, 1'b0, 1'b0);
    b7.mode = MODE_HOLD;
    for (int k = 0; k < 10; k++) begin
      tick(); chk7("mid_hold", 3'd2, 1'b0, 1'b0);
    end
    b7.mode = MODE_AUTO;
    for (int k = 1; k <= 3; k++) begin
      tick(); chk7("reentry_wait", 3'd2, 1'b0, 1'b0);
    end
    tick(); chk7("reentry_adv", 3'd3, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    c7 = {b7.a, b7.b, b7.c};
    chk7("at_four", 3'd4, 1'b1, 1'b0);
    // async reset mid-AUTO with code=4
    tick(); tick();
    rst = 1'b1;
    #1;
    chk7("async_rst", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick(); chk7("post_rst_wait", 3'd0, 1'b0, 1'b0);
    end
    tick(); chk7("post_rst_adv", 3'd1, 1'b1, 1'b0);
    if (c7 != 3'd4) $display("note: pre-reset code was %0d", c7);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/scan_code_gen.md
Name: scan_code_gen

Overview:
- Sequential source of the 3-bit select code (a, b, c) that drives the 3-to-8 decoder directly downstream.
- Produces a registered code that auto-scans at a prescaled rate, single-steps on an external button/strobe, holds, or loads a value.
- Pulses adv and wrap so downstream logic (digit/LED scan, enables) can align to code changes.

Parameters:
- CNT_MAX, 49999, prescaler terminal count; in AUTO the code advances every CNT_MAX+1 clocks (1 ms at 50 MHz).
- LAST_IDX, 7, highest code value used (legal range 1..7); scan range is 0..LAST_IDX.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  2  00 HOLD, 01 AUTO, 10 STEP, 11 LOAD; synchronous to clk.
- dir  input  1  0 = count up, 1 = count down.
- step  input  1  asynchronous step strobe, used in STEP mode.
- load_val  input  3  value loaded in LOAD mode.
- a  output  1  code bit 2 (MSB), to decoder input a.
- b  output  1  code bit 1, to decoder input b.
- c  output  1  code bit 0 (LSB), to decoder input c.
- adv  output  1  one-cycle pulse, high in the first cycle a new code value is present.
- wrap  output  1  one-cycle pulse, high with adv when the code wrapped.

Behaviour:
- Reset (async, rst=1): code=0, a=b=c=0, adv=0, wrap=0, prescaler=0, step synchronizer flops=0. Takes effect immediately. Reset mid-scan abandons the count. The first advance after release requires a full CNT_MAX+1 clocks in AUTO.
- All outputs are registered. a/b/c are the code register bits. adv and wrap are updated on the same edge as the code.
- Advance rule:
  - dir=0: code==LAST_IDX -> 0 with wrap=1; otherwise code+1.
  - dir=1: code==0 -> LAST_IDX with wrap=1; otherwise code-1.
  - Arithmetic is 3-bit. The code never leaves 0..LAST_IDX.
- HOLD: code is frozen. adv=wrap=0. Prescaler is held at 0.
- AUTO:
  - Prescaler counts 0..CNT_MAX.
  - On the edge where the prescaler equals CNT_MAX, the prescaler returns to 0 and the code advances.
  - Leaving AUTO clears the prescaler, so re-entry restarts a full period.
  - A dir change takes effect at the next advance.
- STEP:
  - step passes through a 2-flop synchronizer plus a third flop for edge detect. rise = s2 & ~s3.
  - If step is first sampled high at edge N, the code advances at edge N+2.
  - A held step produces exactly one advance.
  - The synchronizer runs in all modes. Edges outside STEP are discarded, so entering STEP with step already high does not advance.
- LOAD:
  - Each cycle, code <= min(load_val, LAST_IDX).
  - adv=1 only when the loaded value differs from the current code. wrap=0 always.
- Mode decoding: mode is sampled each edge. A mode change applies on that edge with no extra latency.
- Simultaneous events: only the current mode's source can advance, so no conflicts exist.
- adv/wrap: any cycle without an update drives adv=wrap=0.

Decomposition:
- Shared package scan_pkg holds:
  - CODE_W=3.
  - Mode encodings MODE_HOLD=2'b00, MODE_AUTO=2'b01, MODE_STEP=2'b10, MODE_LOAD=2'b11.
  - Direction constants DIR_UP=0, DIR_DN=1.
- One sub-module, step_sync_edge: 2-flop synchronizer plus edge detector producing a one-cycle rise pulse, with async active-high reset on clk/rst.
- Prescaler, code register and mode logic stay in scan_code_gen.

Test Plan (CNT_MAX=3 for simulation):
- AUTO, dir=0, LAST_IDX=7 -> code steps 0,1,...,7,0 every 4 clocks; adv pulses each step; wrap=1 only on 7->0.
- AUTO, dir=1, LAST_IDX=5 -> first advance 0->5 with wrap=1, then 4,3,2,1,0,5; code never 6 or 7.
- STEP, three step pulses each held high 6 clocks -> code 0->1->2->3; each change exactly 2 edges after first high sample; one advance per pulse; step pulses during HOLD -> no change.
- LOAD:
  - load_val=6 -> code 6 next edge, adv=1, wrap=0.
  - Hold load_val=6 -> adv=0.
  - With LAST_IDX=5, load_val=7 -> code 5.
- Switch AUTO->HOLD when prescaler=2, wait 10 clocks, back to AUTO -> code unchanged during HOLD; next advance exactly 4 clocks after re-entry.
- Assert rst for 1 ns mid-AUTO with code=4 -> a=b=c=0, adv=wrap=0 immediately without a clock edge; after release the first advance comes 4 clocks later.
